// File: rtl/turfio_rxclk_phase_ctrl.sv
// Reset/lock/fine-phase sequencer for the TURFIO RXCLK MMCM, running in the PSCLK domain.
// Define RXCLK_PS_AUTO_RELOCK_EN to re-lock automatically when LOCKED drops after lock.
module turfio_rxclk_phase_ctrl #(
    parameter int PS_PERIOD    = 672,
    parameter int PHASE_BITS   = 10,
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 65536
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  locked_i,
    output logic                  mmcm_rst_o,
    output logic                  ps_en_o,
    input  logic                  ps_done_i,
    input  logic [PHASE_BITS-1:0] target_i,
    input  logic                  target_wr_i,
    input  logic                  relock_i,
    output logic [PHASE_BITS-1:0] phase_o,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic                  lock_err_o
);

    localparam int CNT_MAX  = (LOCK_TIMEOUT > RST_CYCLES)
                            ? ((LOCK_TIMEOUT > 64) ? LOCK_TIMEOUT : 64)
                            : ((RST_CYCLES > 64) ? RST_CYCLES : 64);
    localparam int CNT_BITS = $clog2(CNT_MAX + 1);

    localparam logic [CNT_BITS-1:0]   RST_LAST   = CNT_BITS'(RST_CYCLES - 1);
    localparam logic [CNT_BITS-1:0]   LOCK_LAST  = CNT_BITS'(LOCK_TIMEOUT - 1);
    localparam logic [PHASE_BITS:0]   PERIOD_EXT = (PHASE_BITS + 1)'(PS_PERIOD);
    localparam logic [PHASE_BITS-1:0] PHASE_LAST = PHASE_BITS'(PS_PERIOD - 1);
`ifdef RXCLK_PS_AUTO_RELOCK_EN
    localparam logic [CNT_BITS-1:0]   LOST_LAST  = CNT_BITS'(63);
`endif

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_CHECK,
        S_PS_REQ,
        S_PS_WAIT,
        S_IDLE
    } state_t;

    state_t                  state;
    logic [CNT_BITS-1:0]     counter;
    logic                    locked_meta;
    logic                    locked_sync;
    logic [PHASE_BITS-1:0]   target;
    logic                    pending;
    logic                    relock_pend;
    logic                    lock_lost;
    logic                    go_reset;
    logic                    target_valid;

`ifdef RXCLK_PS_AUTO_RELOCK_EN
    assign lock_lost = ~locked_sync;
`else
    assign lock_lost = 1'b0;
`endif

    assign target_valid = ({1'b0, target_i} < PERIOD_EXT);
    assign busy_o       = (state != S_IDLE);
    assign ready_o      = (state == S_IDLE) & locked_sync & ~pending;

    // Requests that abort the current activity and restart the MMCM with the target re-applied.
    always_comb begin
        go_reset = 1'b0;
        case (state)
            S_WAIT_LOCK: go_reset = relock_i;
            S_CHECK:     go_reset = relock_i | relock_pend | lock_lost;
            S_IDLE:      go_reset = relock_i | lock_lost;
`ifdef RXCLK_PS_AUTO_RELOCK_EN
            S_PS_WAIT:   go_reset = lock_lost & (ps_done_i | (counter == LOST_LAST));
`endif
            default:     go_reset = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_RESET;
            counter     <= '0;
            locked_meta <= 1'b0;
            locked_sync <= 1'b0;
            mmcm_rst_o  <= 1'b1;
            ps_en_o     <= 1'b0;
            phase_o     <= '0;
            lock_err_o  <= 1'b0;
            target      <= '0;
            pending     <= 1'b0;
            relock_pend <= 1'b0;
        end else begin
            locked_meta <= locked_i;
            locked_sync <= locked_meta;
            ps_en_o     <= 1'b0;

            if (go_reset) begin
                state       <= S_RESET;
                counter     <= '0;
                mmcm_rst_o  <= 1'b1;
                phase_o     <= '0;
                relock_pend <= 1'b0;
                pending     <= (target != '0);
            end else begin
                case (state)
                    S_RESET: begin
                        phase_o <= '0;
                        if (counter == RST_LAST) begin
                            state      <= S_WAIT_LOCK;
                            counter    <= '0;
                            mmcm_rst_o <= 1'b0;
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (locked_sync) begin
                            state   <= S_CHECK;
                            counter <= '0;
                        end else if (counter == LOCK_LAST) begin
                            lock_err_o <= 1'b1;
                            state      <= S_RESET;
                            counter    <= '0;
                            mmcm_rst_o <= 1'b1;
                            pending    <= (target != '0);
                        end else begin
                            counter <= counter + 1'b1;
                        end
                    end
                    S_CHECK: begin
                        if (pending && (target != phase_o)) begin
                            state   <= S_PS_REQ;
                            ps_en_o <= 1'b1;
                        end else begin
                            pending <= 1'b0;
                            state   <= S_IDLE;
                        end
                    end
                    S_PS_REQ: begin
                        state   <= S_PS_WAIT;
                        counter <= '0;
                    end
                    S_PS_WAIT: begin
                        // Increment-only shifter: the phase wraps at the end of one RXCLK period.
                        if (ps_done_i) begin
                            phase_o <= (phase_o == PHASE_LAST) ? '0 : phase_o + 1'b1;
                            state   <= S_CHECK;
                        end
`ifdef RXCLK_PS_AUTO_RELOCK_EN
                        else if (lock_lost) begin
                            counter <= counter + 1'b1;
                        end
`endif
                    end
                    S_IDLE: begin
                        if (pending) begin
                            state <= S_CHECK;
                        end
                    end
                    default: state <= S_RESET;
                endcase
            end

            if (relock_i) begin
                lock_err_o <= 1'b0;
            end

            // A step already handed to the MMCM must finish before the relock is honoured.
            if (relock_i && !go_reset && ((state == S_PS_REQ) || (state == S_PS_WAIT))) begin
                relock_pend <= 1'b1;
            end

            if (target_wr_i && target_valid) begin
                target  <= target_i;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_turfio_rxclk_phase_ctrl.sv
// Directed plus randomized bench for turfio_rxclk_phase_ctrl with a PSDONE responder model.
module tb_turfio_rxclk_phase_ctrl;

    localparam int P  = 672;
    localparam int LT = 512;

    logic       clk_i       = 1'b0;
    logic       rst_i       = 1'b1;
    logic       locked_i    = 1'b0;
    logic       ps_done_i   = 1'b0;
    logic       target_wr_i = 1'b0;
    logic       relock_i    = 1'b0;
    logic [9:0] target_i    = '0;
    logic       mmcm_rst_o;
    logic       ps_en_o;
    logic [9:0] phase_o;
    logic       busy_o;
    logic       ready_o;
    logic       lock_err_o;

    turfio_rxclk_phase_ctrl #(
        .PS_PERIOD   (P),
        .PHASE_BITS  (10),
        .RST_CYCLES  (16),
        .LOCK_TIMEOUT(LT)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .locked_i   (locked_i),
        .mmcm_rst_o (mmcm_rst_o),
        .ps_en_o    (ps_en_o),
        .ps_done_i  (ps_done_i),
        .target_i   (target_i),
        .target_wr_i(target_wr_i),
        .relock_i   (relock_i),
        .phase_o    (phase_o),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .lock_err_o (lock_err_o)
    );

    always #5 clk_i = ~clk_i;

    int         total = 0;
    int         bad = 0;
    int         ps_pulses = 0;
    int         ps_violations = 0;
    int         done_delay = 0;
    int         resp_cnt = 0;
    bit         resp_wait = 1'b0;
    bit         prev_en = 1'b0;
    int         rst_rises = 0;
    int         rst_run = 0;
    int         last_rst_len = 0;
    int         phase_log[$];
    logic [9:0] last_phase;
    int         out_of_range = 0;

    // MMCM phase-shift model: PSDONE returns a fixed or random number of cycles after each PSEN.
    always @(negedge clk_i) begin
        ps_done_i = 1'b0;
        if (resp_wait) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0) begin
                ps_done_i = 1'b1;
                resp_wait = 1'b0;
            end
        end
        if (ps_en_o === 1'b1) begin
            ps_pulses = ps_pulses + 1;
            if (resp_wait || prev_en) ps_violations = ps_violations + 1;
            resp_wait = 1'b1;
            resp_cnt  = (done_delay > 0) ? done_delay : int'($urandom_range(2, 6));
        end
        prev_en = (ps_en_o === 1'b1);
    end

    // Observers for MMCM reset pulse lengths and the sequence of phase values.
    always @(negedge clk_i) begin
        if (mmcm_rst_o === 1'b1) begin
            if (rst_run == 0) rst_rises = rst_rises + 1;
            rst_run = rst_run + 1;
        end else begin
            if (rst_run != 0) last_rst_len = rst_run;
            rst_run = 0;
        end
        if (phase_o !== last_phase) begin
            phase_log.push_back(int'(phase_o));
            last_phase = phase_o;
        end
        if (phase_o >= 10'(P)) out_of_range = 1;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic checkOutput(input string tag, input integer observed, input integer expected);
        total = total + 1;
        assert (observed === expected) else begin
            bad = bad + 1;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit wr, input int tgt, input bit relock);
        target_wr_i = wr;
        target_i    = 10'(tgt);
        relock_i    = relock;
        tick(1);
        target_wr_i = 1'b0;
        relock_i    = 1'b0;
    endtask

    task automatic waitReady(input string tag, input int budget);
        int n = 0;
        while (!(ready_o === 1'b1 && busy_o === 1'b0) && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(tag, (n < budget) ? 1 : 0, 1);
    endtask

    task automatic waitRst(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (mmcm_rst_o !== lvl && n < budget) begin
            tick(1);
            n++;
        end
        checkOutput(tag, (n < budget) ? 1 : 0, 1);
    endtask

    initial begin
        int cur;
        int n;
        int rises0;
        int exp_seq[4];
        exp_seq = '{671, 0, 1, 2};

        $display("[TB] start");
        tick(1);
        checkOutput("rst_mmcm_rst", mmcm_rst_o, 1);
        checkOutput("rst_ps_en", ps_en_o, 0);
        checkOutput("rst_phase", phase_o, 0);
        checkOutput("rst_busy", busy_o, 1);
        checkOutput("rst_ready", ready_o, 0);
        checkOutput("rst_lock_err", lock_err_o, 0);
        rst_i = 1'b0;

        // Power-up: reset pulse, lock 100 cycles later, settle to ready
        waitRst(1'b0, 40, "t1_rst_release");
        tick(1);
        checkOutput("t1_rst_len", last_rst_len, 16);
        tick(99);
        locked_i = 1'b1;
        n = 0;
        while (ready_o !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        checkOutput("t1_ready_latency_ok", (n >= 2 && n <= 6) ? 1 : 0, 1);
        checkOutput("t1_phase", phase_o, 0);
        checkOutput("t1_lock_err", lock_err_o, 0);
        checkOutput("t1_mmcm_rst", mmcm_rst_o, 0);

        // Five steps with a slow PSDONE
        done_delay = 12;
        ps_pulses  = 0;
        applyStimulus(1'b1, 5, 1'b0);
        waitReady("t2_ready", 2000);
        checkOutput("t2_pulses", ps_pulses, 5);
        checkOutput("t2_phase", phase_o, 5);
        checkOutput("t2_ready_hi", ready_o, 1);
        done_delay = 0;
        cur = 5;

        // Wrap through the end of the period
        ps_pulses = 0;
        applyStimulus(1'b1, 670, 1'b0);
        waitReady("t3_ready_670", 8000);
        checkOutput("t3_phase_670", phase_o, 670);
        checkOutput("t3_pulses_670", ps_pulses, (670 - cur + P) % P);
        ps_pulses = 0;
        phase_log.delete();
        applyStimulus(1'b1, 2, 1'b0);
        waitReady("t3_ready_2", 2000);
        checkOutput("t3_pulses_wrap", ps_pulses, 4);
        checkOutput("t3_log_size", phase_log.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput("t3_phase_seq", (i < phase_log.size()) ? phase_log[i] : -1, exp_seq[i]);
        ps_pulses = 0;
        applyStimulus(1'b1, P, 1'b0);
        tick(20);
        checkOutput("t3_invalid_pulses", ps_pulses, 0);
        checkOutput("t3_invalid_phase", phase_o, 2);
        checkOutput("t3_invalid_ready", ready_o, 1);

        // Latest write wins: redirect before the first step lands
        ps_pulses = 0;
        applyStimulus(1'b1, 52, 1'b0);
        tick(3);
        applyStimulus(1'b1, 22, 1'b0);
        waitReady("t3_ready_redirect", 2000);
        checkOutput("t3_redirect_phase", phase_o, 22);
        checkOutput("t3_redirect_pulses", ps_pulses, 20);
        cur = 22;

        // Random targets with ignored out-of-range writes landing mid-stepping
        for (int it = 0; it < 4; it++) begin
            int t;
            int junk;
            t    = int'($urandom_range(0, P - 1));
            junk = int'($urandom_range(P, 1023));
            ps_pulses = 0;
            applyStimulus(1'b1, t, 1'b0);
            tick(int'($urandom_range(0, 30)));
            applyStimulus(1'b1, junk, 1'b0);
            waitReady("rnd_ready", 8000);
            checkOutput("rnd_phase", phase_o, t);
            checkOutput("rnd_pulses", ps_pulses, (t - cur + P) % P);
            cur = t;
        end

        // Relock while a step is in flight: the step completes, then re-lock and re-apply
        ps_pulses = 0;
        applyStimulus(1'b1, 300, 1'b0);
        waitReady("t5_ready_300", 8000);
        checkOutput("t5_phase_300", phase_o, 300);
        checkOutput("t5_pulses_300", ps_pulses, (300 - cur + P) % P);
        ps_pulses = 0;
        phase_log.delete();
        rises0 = rst_rises;
        applyStimulus(1'b1, 310, 1'b0);
        n = 0;
        while (ps_en_o !== 1'b1 && n < 50) begin
            tick(1);
            n++;
        end
        checkOutput("t5_first_pulse", (n < 50) ? 1 : 0, 1);
        tick(1);
        applyStimulus(1'b0, 0, 1'b1);
        waitReady("t5_ready_310", 8000);
        checkOutput("t5_phase_310", phase_o, 310);
        checkOutput("t5_pulses", ps_pulses, 311);
        checkOutput("t5_rst_pulses", rst_rises - rises0, 1);
        checkOutput("t5_step_completed", (phase_log.size() > 0) ? phase_log[0] : -1, 301);
        checkOutput("t5_phase_cleared", (phase_log.size() > 1) ? phase_log[1] : -1, 0);

        // Lock loss in IDLE, then lock timeout and retry
        rises0   = rst_rises;
        locked_i = 1'b0;
        tick(8);
        checkOutput("t6_ready_low", ready_o, 0);
`ifdef RXCLK_PS_AUTO_RELOCK_EN
        checkOutput("t6_auto_rst", rst_rises - rises0, 1);
        checkOutput("t6_auto_phase", phase_o, 0);
`else
        tick(50);
        checkOutput("t6_no_rst", rst_rises - rises0, 0);
        checkOutput("t6_phase_kept", phase_o, 310);
        checkOutput("t6_idle", busy_o, 0);
        applyStimulus(1'b0, 0, 1'b1);
`endif
        waitRst(1'b1, 10, "t4_rst_start");
        waitRst(1'b0, 40, "t4_rst_end");
        n = 0;
        while (lock_err_o !== 1'b1 && n < LT + 50) begin
            tick(1);
            n++;
        end
        checkOutput("t4_timeout_cycles", n, LT);
        checkOutput("t4_retry_rst", mmcm_rst_o, 1);
        checkOutput("t4_phase", phase_o, 0);
        waitRst(1'b0, 40, "t4_retry_end");
        tick(1);
        checkOutput("t4_retry_len", last_rst_len, 16);
        checkOutput("t4_err_sticky", lock_err_o, 1);
        applyStimulus(1'b0, 0, 1'b1);
        checkOutput("t4_err_cleared", lock_err_o, 0);
        ps_pulses = 0;
        locked_i  = 1'b1;
        waitReady("t4_ready", 8000);
        checkOutput("t4_phase_reapplied", phase_o, 310);
        checkOutput("t4_pulses_reapplied", ps_pulses, 310);
        checkOutput("t4_err_final", lock_err_o, 0);

        checkOutput("ps_protocol", ps_violations, 0);
        checkOutput("phase_range", out_of_range, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
